// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and helpers for the SDRAM command arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, ISSUE)
//   NumPortsMax  : largest supported requester count
//   TagWidth     : bits needed to name any requester (also the tag FIFO width)
//   rr_pick()    : round-robin selection starting one past the last winner
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int NumPortsMax = 4;
    localparam int TagWidth    = $clog2(NumPortsMax);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    // Scan eligible ports starting at rr_ptr+1 (mod num_ports) and return the
    // first one found. The caller only uses the result when eligible is non-zero.
    function automatic logic [TagWidth-1:0] rr_pick(
        input logic [NumPortsMax-1:0] eligible,
        input logic [TagWidth-1:0]    rr_ptr,
        input int                     num_ports
    );
        logic [TagWidth-1:0] pick;
        logic [TagWidth-1:0] idx;
        logic                found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NumPortsMax; k++) begin
            if (k <= num_ports) begin
                idx = TagWidth'((int'(rr_ptr) + k) % num_ports);
                if (!found && eligible[idx]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// -----------------------------------------------------------------------------
// sdram_arb_tag_fifo
// Small synchronous FIFO remembering which requester issued each outstanding
// read, so returning read data can be steered back in order.
// Ports:
//   clk, rst_   : clock, asynchronous active-low reset (empties the FIFO)
//   push, din   : enqueue din
//   pop, dout   : dequeue; dout shows the oldest entry while not empty
//   full, empty : occupancy flags
// A push and a pop on the same edge both take effect, even when full.
// -----------------------------------------------------------------------------
module sdram_arb_tag_fifo #(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem [Depth];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth:0]   count;
    logic                do_push;
    logic                do_pop;

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        full    = (count == (PtrWidth+1)'(Depth));
        empty   = (count == '0);
        dout    = mem[rd_ptr];
    end

    // Pointers and occupancy; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_cmd_arbiter
// Shares one SDRAM controller command port between NumPorts requesters.
// A winner is registered onto cmd* and held until cmdReady; reads remember
// their issuer in a tag FIFO so in-order read data goes back to the right port.
//
// Ports:
//   clk, rst_            : clock, asynchronous active-low reset
//   req_trigger/write    : per-port request and direction (held until req_ready)
//   req_addr/req_wdata   : per-port packed address / write data
//   req_ready            : per-port accept pulse (same cycle as cmdReady)
//   rsp_valid/rsp_data   : per-port read-data strobe, shared read data
//   cmdTrigger/cmdAddr/cmdWrite/cmdWriteData/cmdReady : controller command port
//   cmdReadData/cmdReadDataValid                      : controller read return
//   tag_err              : sticky, read data arrived with no outstanding read
//
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest
// eligible index wins); otherwise round-robin.
// -----------------------------------------------------------------------------
module sdram_cmd_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int AddrWidth = 23,
    parameter int DataWidth = 16,
    parameter int TagDepth  = 4
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NumPorts-1:0]           req_trigger,
    output logic [NumPorts-1:0]           req_ready,
    input  logic [NumPorts-1:0]           req_write,
    input  logic [NumPorts*AddrWidth-1:0] req_addr,
    input  logic [NumPorts*DataWidth-1:0] req_wdata,
    output logic [NumPorts-1:0]           rsp_valid,
    output logic [DataWidth-1:0]          rsp_data,
    input  logic                          cmdReady,
    output logic                          cmdTrigger,
    output logic [AddrWidth-1:0]          cmdAddr,
    output logic                          cmdWrite,
    output logic [DataWidth-1:0]          cmdWriteData,
    input  logic [DataWidth-1:0]          cmdReadData,
    input  logic                          cmdReadDataValid,
    output logic                          tag_err
);

    arb_state_t            state;
    logic [TagWidth-1:0]   grant;
    logic [TagWidth-1:0]   pick;
    logic [NumPorts-1:0]   eligible;
    logic                  tag_full;
    logic                  tag_empty;
    logic                  tag_push;
    logic                  tag_pop;
    logic [TagWidth-1:0]   tag_dout;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic [TagWidth-1:0]   rr_ptr;
`endif

    // A full tag FIFO only holds back reads; writes never need a tag.
    always_comb begin
        eligible = req_trigger & (req_write | {NumPorts{~tag_full}});
    end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        pick = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (eligible[i]) pick = TagWidth'(i);
        end
    end
`else
    // Round-robin: start one past the port that won last.
    always_comb begin
        pick = rr_pick(NumPortsMax'(eligible), rr_ptr, NumPorts);
    end
`endif

    // Arbiter FSM: IDLE registers the winner onto the command port, ISSUE
    // holds it stable until the controller accepts it.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state        <= IDLE;
            grant        <= '0;
            cmdTrigger   <= 1'b0;
            cmdAddr      <= '0;
            cmdWrite     <= 1'b0;
            cmdWriteData <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr_ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        grant        <= pick;
                        cmdAddr      <= req_addr[int'(pick)*AddrWidth +: AddrWidth];
                        cmdWrite     <= req_write[pick];
                        cmdWriteData <= req_wdata[int'(pick)*DataWidth +: DataWidth];
                        cmdTrigger   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmdReady) begin
                        cmdTrigger <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        rr_ptr     <= grant;
`endif
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The accept pulse mirrors cmdReady combinationally so the requester can
    // move on right after the accepting edge. Accepted reads record their issuer.
    always_comb begin
        req_ready = '0;
        if (state == ISSUE && cmdReady) req_ready = NumPorts'(1) << grant;
        tag_push = (state == ISSUE) && cmdReady && !cmdWrite;
        tag_pop  = cmdReadDataValid && !tag_empty;
    end

    // Read return: one registered cycle from controller data to the issuer.
    // Data with no outstanding tag is dropped and flagged until reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            tag_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (tag_pop) begin
                rsp_valid <= NumPorts'(1) << tag_dout;
                rsp_data  <= cmdReadData;
            end
            if (cmdReadDataValid && tag_empty) tag_err <= 1'b1;
        end
    end

    sdram_arb_tag_fifo #(
        .Depth (TagDepth),
        .Width (TagWidth)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (tag_push),
        .pop   (tag_pop),
        .din   (grant),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_arbiter
// Self-checking bench for sdram_cmd_arbiter. Stimulus queues commands per
// port and pushes hand-computed expected grants/responses into scoreboards;
// a negedge monitor pops and compares whenever the DUT accepts a command or
// presents read data. Expected orders follow SDRAM_ARB_FIXED_PRIO_EN if defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_cmd_arbiter;

    localparam int NumPorts  = 2;
    localparam int AddrWidth = 23;
    localparam int DataWidth = 16;
    localparam int TagDepth  = 4;

    typedef struct packed {
        logic [1:0]           port;
        logic                 write;
        logic [AddrWidth-1:0] addr;
        logic [DataWidth-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [1:0]           port;
        logic [DataWidth-1:0] data;
    } rsp_t;

    logic                          clk = 1'b0;
    logic                          rst_;
    logic [NumPorts-1:0]           req_trigger;
    logic [NumPorts-1:0]           req_ready;
    logic [NumPorts-1:0]           req_write;
    logic [NumPorts*AddrWidth-1:0] req_addr;
    logic [NumPorts*DataWidth-1:0] req_wdata;
    logic [NumPorts-1:0]           rsp_valid;
    logic [DataWidth-1:0]          rsp_data;
    logic                          cmdReady;
    logic                          cmdTrigger;
    logic [AddrWidth-1:0]          cmdAddr;
    logic                          cmdWrite;
    logic [DataWidth-1:0]          cmdWriteData;
    logic [DataWidth-1:0]          cmdReadData;
    logic                          cmdReadDataValid;
    logic                          tag_err;

    int   check_count = 0;
    int   error_count = 0;
    cmd_t port_q [NumPorts][$];
    cmd_t exp_cmd_q [$];
    rsp_t exp_rsp_q [$];
    logic drv_busy [NumPorts];

    sdram_cmd_arbiter #(
        .NumPorts  (NumPorts),
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth),
        .TagDepth  (TagDepth)
    ) dut (
        .clk              (clk),
        .rst_             (rst_),
        .req_trigger      (req_trigger),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .cmdReady         (cmdReady),
        .cmdTrigger       (cmdTrigger),
        .cmdAddr          (cmdAddr),
        .cmdWrite         (cmdWrite),
        .cmdWriteData     (cmdWriteData),
        .cmdReadData      (cmdReadData),
        .cmdReadDataValid (cmdReadDataValid),
        .tag_err          (tag_err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] actual);
        check_count++;
        error_count++;
        $display("[TB] FAIL %s: observed 0x%0h, nothing expected", name, actual);
    endtask

    task automatic applyStimulus(input int port, input logic write, input logic [AddrWidth-1:0] addr,
                                 input logic [DataWidth-1:0] wdata);
        port_q[port].push_back('{port: 2'(port), write: write, addr: addr, wdata: wdata});
    endtask

    task automatic expectCmd(input int port, input logic write, input logic [AddrWidth-1:0] addr,
                             input logic [DataWidth-1:0] wdata);
        exp_cmd_q.push_back('{port: 2'(port), write: write, addr: addr, wdata: wdata});
    endtask

    task automatic expectRsp(input int port, input logic [DataWidth-1:0] data);
        exp_rsp_q.push_back('{port: 2'(port), data: data});
    endtask

    function automatic bit busyAny();
        bit b = (exp_cmd_q.size() != 0);
        for (int i = 0; i < NumPorts; i++) b = b || (port_q[i].size() != 0) || drv_busy[i];
        return b;
    endfunction

    task automatic flushAll();
        for (int i = 0; i < NumPorts; i++) port_q[i].delete();
        exp_cmd_q.delete();
        exp_rsp_q.delete();
    endtask

    // Wait (bounded) until every queued command was accepted; ends at posedge+3.
    task automatic waitDrain(input int budget);
        int n = 0;
        while (busyAny() && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (busyAny()) begin
            reportFail("drain_timeout", 32'(exp_cmd_q.size()));
            flushAll();
        end
        @(posedge clk);
        #3;
    endtask

    task automatic waitRsp(input int budget);
        int n = 0;
        while (exp_rsp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_rsp_q.size() != 0) begin
            reportFail("rsp_timeout", 32'(exp_rsp_q.size()));
            exp_rsp_q.delete();
        end
        @(posedge clk);
        #3;
    endtask

    // Controller read return for exactly one sampled edge.
    task automatic returnData(input logic [DataWidth-1:0] d);
        cmdReadDataValid = 1'b1;
        cmdReadData      = d;
        @(posedge clk);
        #3;
        cmdReadDataValid = 1'b0;
    endtask

    task automatic doReset();
        rst_ = 1'b0;
        flushAll();
        repeat (2) @(posedge clk);
        #3;
        rst_ = 1'b1;
    endtask

    // Single write with the trigger-to-cmdTrigger latency checked directly.
    task automatic checkWriteLatency(input int port, input logic [AddrWidth-1:0] addr,
                                     input logic [DataWidth-1:0] wdata);
        applyStimulus(port, 1'b1, addr, wdata);
        expectCmd(port, 1'b1, addr, wdata);
        @(negedge clk);
        @(negedge clk);
        checkOutput("lat_trigger_before_cmd", {31'd0, req_trigger[port]} << 1 | {31'd0, cmdTrigger}, 32'b10);
        @(negedge clk);
        checkOutput("lat_cmd_trigger", {31'd0, cmdTrigger}, 32'd1);
        waitDrain(20);
    endtask

    // Requester model: presents queued commands and holds them until req_ready,
    // then presents the next one (or drops trigger) just after the accepting edge.
    initial begin : driver
        logic acc [NumPorts];
        cmd_t c;
        req_trigger = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        for (int i = 0; i < NumPorts; i++) drv_busy[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NumPorts; i++) acc[i] = req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < NumPorts; i++) begin
                if (!rst_) drv_busy[i] = 1'b0;
                else if (drv_busy[i] && acc[i]) drv_busy[i] = 1'b0;
                if (!drv_busy[i]) begin
                    if (rst_ && port_q[i].size() > 0) begin
                        c = port_q[i].pop_front();
                        req_trigger[i] = 1'b1;
                        req_write[i]   = c.write;
                        req_addr[i*AddrWidth +: AddrWidth]  = c.addr;
                        req_wdata[i*DataWidth +: DataWidth] = c.wdata;
                        drv_busy[i] = 1'b1;
                    end else begin
                        req_trigger[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares every accepted command and every read response.
    always @(negedge clk) begin
        cmd_t e;
        rsp_t r;
        if (rst_) begin
            if (cmdTrigger && cmdReady) begin
                if (exp_cmd_q.size() == 0) begin
                    reportFail("unexpected_cmd_addr", 32'(cmdAddr));
                end else begin
                    e = exp_cmd_q.pop_front();
                    checkOutput("grant_req_ready", 32'(req_ready), 32'(1) << e.port);
                    checkOutput("grant_cmdAddr", 32'(cmdAddr), 32'(e.addr));
                    checkOutput("grant_cmdWrite", 32'(cmdWrite), 32'(e.write));
                    checkOutput("grant_cmdWriteData", 32'(cmdWriteData), 32'(e.wdata));
                end
            end else begin
                checkOutput("ready_idle", 32'(req_ready), 32'd0);
            end
            if (rsp_valid != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    reportFail("unexpected_rsp_valid", 32'(rsp_valid));
                end else begin
                    r = exp_rsp_q.pop_front();
                    checkOutput("rsp_port", 32'(rsp_valid), 32'(1) << r.port);
                    checkOutput("rsp_data", 32'(rsp_data), 32'(r.data));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        reportFail("watchdog", 32'(check_count));
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst_             = 1'b0;
        cmdReady         = 1'b1;
        cmdReadDataValid = 1'b0;
        cmdReadData      = '0;
        repeat (2) @(posedge clk);
        #3;
        $display("[TB] reset values");
        checkOutput("rst_cmdTrigger", 32'(cmdTrigger), 32'd0);
        checkOutput("rst_cmdAddr", 32'(cmdAddr), 32'd0);
        checkOutput("rst_cmdWrite", 32'(cmdWrite), 32'd0);
        checkOutput("rst_cmdWriteData", 32'(cmdWriteData), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_tag_err", 32'(tag_err), 32'd0);
        rst_ = 1'b1;

        $display("[TB] single write");
        checkWriteLatency(0, 23'h000042, 16'h00A5);

        $display("[TB] spurious return (also shows the write pushed no tag)");
        returnData(16'hDEAD);
        repeat (2) @(posedge clk);
        #3;
        checkOutput("spurious_tag_err", 32'(tag_err), 32'd1);
        checkOutput("spurious_rsp_data", 32'(rsp_data), 32'd0);
        repeat (5) @(posedge clk);
        #3;
        checkOutput("spurious_tag_err_sticky", 32'(tag_err), 32'd1);
        doReset();
        checkOutput("tag_err_cleared", 32'(tag_err), 32'd0);

        $display("[TB] contention");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b1, 23'h000100 + 23'(k), 16'h1000 + 16'(k));
            applyStimulus(1, 1'b1, 23'h000200 + 23'(k), 16'h2000 + 16'(k));
        end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) expectCmd(0, 1'b1, 23'h000100 + 23'(k), 16'h1000 + 16'(k));
        for (int k = 0; k < 4; k++) expectCmd(1, 1'b1, 23'h000200 + 23'(k), 16'h2000 + 16'(k));
`else
        for (int k = 0; k < 4; k++) begin
            expectCmd(1, 1'b1, 23'h000200 + 23'(k), 16'h2000 + 16'(k));
            expectCmd(0, 1'b1, 23'h000100 + 23'(k), 16'h1000 + 16'(k));
        end
`endif
        waitDrain(60);

        $display("[TB] read routing");
        applyStimulus(1, 1'b0, 23'h001000, 16'h0000);
        expectCmd(1, 1'b0, 23'h001000, 16'h0000);
        waitDrain(20);
        applyStimulus(0, 1'b0, 23'h002000, 16'h0000);
        expectCmd(0, 1'b0, 23'h002000, 16'h0000);
        waitDrain(20);
        expectRsp(1, 16'hBEEF);
        returnData(16'hBEEF);
        expectRsp(0, 16'h1234);
        returnData(16'h1234);
        waitRsp(10);
        repeat (3) @(posedge clk);
        #3;
        checkOutput("rsp_data_hold", 32'(rsp_data), 32'h1234);

        $display("[TB] tag full");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1'b0, 23'h003000 + 23'(k), 16'h0000);
            expectCmd(0, 1'b0, 23'h003000 + 23'(k), 16'h0000);
        end
        waitDrain(40);
        applyStimulus(0, 1'b0, 23'h004000, 16'h0000);
        applyStimulus(1, 1'b1, 23'h005000, 16'h5A5A);
        expectCmd(1, 1'b1, 23'h005000, 16'h5A5A);
        repeat (8) @(posedge clk);
        #3;
        checkOutput("full_write_passed", 32'(exp_cmd_q.size()), 32'd0);
        checkOutput("full_read_held", {30'd0, drv_busy[0], cmdTrigger}, 32'b10);
        expectCmd(0, 1'b0, 23'h004000, 16'h0000);
        expectRsp(0, 16'h0111);
        returnData(16'h0111);
        waitDrain(20);
        expectRsp(0, 16'h0222);
        returnData(16'h0222);
        expectRsp(0, 16'h0333);
        returnData(16'h0333);
        expectRsp(0, 16'h0444);
        returnData(16'h0444);
        expectRsp(0, 16'h0555);
        returnData(16'h0555);
        waitRsp(10);

        $display("[TB] reset during ISSUE");
        applyStimulus(0, 1'b0, 23'h006000, 16'h0000);
        expectCmd(0, 1'b0, 23'h006000, 16'h0000);
        waitDrain(20);
        cmdReady = 1'b0;
        applyStimulus(1, 1'b1, 23'h007000, 16'h7777);
        n = 0;
        @(negedge clk);
        while (cmdTrigger !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("issue_reached", 32'(cmdTrigger), 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        checkOutput("async_rst_cmdTrigger", 32'(cmdTrigger), 32'd0);
        checkOutput("async_rst_cmdAddr", 32'(cmdAddr), 32'd0);
        checkOutput("async_rst_req_ready", 32'(req_ready), 32'd0);
        flushAll();
        repeat (2) @(posedge clk);
        #3;
        rst_     = 1'b1;
        cmdReady = 1'b1;
        returnData(16'hCAFE);
        repeat (2) @(posedge clk);
        #3;
        checkOutput("rst_fifo_emptied", 32'(tag_err), 32'd1);
        checkWriteLatency(1, 23'h007001, 16'h7778);

        checkOutput("end_cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
        checkOutput("end_rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Shares the single SDRAMController command port (cmdTrigger/cmdReady handshake, in-order read return) between NumPorts requesters, e.g. a UART debug console and a pixel-capture writer.
- Round-robin arbitration; registers the winning command toward the controller.
- Tracks the issuer of each outstanding read in a tag FIFO and routes cmdReadData back to that requester.

Parameters:
NumPorts, 2, number of requesters (2..4)
AddrWidth, 23, SDRAM word address width
DataWidth, 16, SDRAM data width
TagDepth, 4, max outstanding reads (power of 2)

Ports:
clk  in  1  system clock
rst_  in  1  asynchronous active-low reset
req_trigger  in  NumPorts  per-port command request, held until req_ready
req_ready  out  NumPorts  per-port one-cycle accept pulse
req_write  in  NumPorts  1=write, 0=read
req_addr  in  NumPorts*AddrWidth  per-port address, packed port i at [i*AddrWidth +: AddrWidth]
req_wdata  in  NumPorts*DataWidth  per-port write data, packed likewise
rsp_valid  out  NumPorts  one-cycle read-data-valid for the issuing port
rsp_data  out  DataWidth  read data, shared by all ports, qualified by rsp_valid
cmdReady  in  1  controller ready
cmdTrigger  out  1  controller command strobe
cmdAddr  out  AddrWidth  controller address
cmdWrite  out  1  controller write flag
cmdWriteData  out  DataWidth  controller write data
cmdReadData  in  DataWidth  controller read data
cmdReadDataValid  in  1  controller read data valid
tag_err  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (rst_ low, async) clears all of the following:
  - cmdTrigger=0, cmdAddr/cmdWrite/cmdWriteData=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, tag_err=0.
  - Tag FIFO emptied; rr pointer=0; FSM=IDLE.
  - Outstanding reads are discarded.
- FSM states IDLE and ISSUE.
- IDLE:
  - Eligible port i = req_trigger[i] && (req_write[i] || !tag_full).
  - If any port is eligible, choose the first eligible port scanning from rr_ptr+1 mod NumPorts.
  - Register its addr/write/wdata onto cmd*, set cmdTrigger=1, latch grant=i, go to ISSUE.
- ISSUE:
  - cmd* and cmdTrigger are held stable.
  - When cmdReady=1: req_ready[grant]=1 combinationally that same cycle; next edge cmdTrigger=0, rr_ptr=grant, FSM=IDLE.
  - If the granted command is a read, push grant into the tag FIFO on that accept edge.
- Throughput: at most one command per 2 cycles; arbiter adds 1 cycle latency from req_trigger to cmdTrigger.
- Requester contract: keep trigger/addr/write/wdata stable until req_ready; drop trigger or present a new command the cycle after.
- Read return:
  - On cmdReadDataValid with FIFO non-empty: pop the tag; next cycle rsp_valid[tag]=1 for one cycle and rsp_data=cmdReadData (1-cycle registered latency).
  - On cmdReadDataValid with FIFO empty: no rsp_valid; tag_err set until reset.
- Push and pop on the same edge: both occur, count unchanged; legal even when full.
- tag_full blocks read grants only. Writes from any port still proceed; a blocked read does not stall other ports.
- rsp_data holds its last value when rsp_valid=0.

Optional Feature:
- SDRAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest eligible index wins; rr_ptr unused.
- Undefined: round-robin as above.
- Handshake and tag logic are identical in both cases.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum {IDLE, ISSUE}
  - TagWidth = $clog2(NumPortsMax=4)
  - helper function rr_pick(eligible, rr_ptr)
- Sub-module sdram_arb_tag_fifo:
  - synchronous FIFO, TagDepth x TagWidth, async active-low reset.
  - ports push/pop/din/dout/full/empty.

Test Plan:
- Single write: port0 write addr 0x000042, wdata 0x00A5, cmdReady=1 -> cmdTrigger 1 cycle after trigger, req_ready[0] pulses once, cmdAddr=0x000042, cmdWriteData=0x00A5, no tag pushed.
- Contention: ports 0 and 1 both hold write triggers continuously, cmdReady=1 -> grants alternate 1,0,1,0 (rr_ptr starts 0); same stimulus with SDRAM_ARB_FIXED_PRIO_EN -> port0 granted every time.
- Read routing: port1 read 0x1000, then port0 read 0x2000; controller returns 0xBEEF, then 0x1234 -> rsp_valid[1] with 0xBEEF, then rsp_valid[0] with 0x1234.
- Tag full: TagDepth=4, issue 4 reads with no return, then port0 read plus port1 write -> port1 write granted, port0 read held; one cmdReadDataValid -> port0 read granted.
- Spurious return: cmdReadDataValid with no outstanding reads -> no rsp_valid, tag_err=1, stays 1.
- Reset mid-ISSUE: rst_ low while cmdTrigger=1 and cmdReady=0 -> cmdTrigger=0 immediately (async), FIFO empty, FSM IDLE after release.
